// File: rtl/fetch_pkg.sv
// Shared defaults and entry layout for the decoupled RV32I fetch stage.
package fetch_pkg;

  localparam int              PC_W_DEF     = 32;
  localparam int              INST_W_DEF   = 32;
  localparam logic [31:0]     RESET_PC_DEF = 32'h0000_0000;
  localparam int              PC_STEP_DEF  = 4;
  localparam int              QDEPTH_DEF   = 4;

  typedef struct packed {
    logic [PC_W_DEF-1:0]   pc;
    logic [INST_W_DEF-1:0] inst;
    logic                  filled;
  } entry_t;

endpackage

// File: rtl/fetch_qmem.sv
// Fetch queue storage: allocate writes the PC, fill writes the instruction,
// read port is combinational at the index chosen by the controller.
module fetch_qmem #(
  parameter int PC_W   = 32,
  parameter int INST_W = 32,
  parameter int QDEPTH = 4,
  localparam int PTR_W = $clog2(QDEPTH)
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              clear,
  input  logic              alloc_en,
  input  logic [PTR_W-1:0]  alloc_idx,
  input  logic [PC_W-1:0]   alloc_pc,
  input  logic              fill_en,
  input  logic [PTR_W-1:0]  fill_idx,
  input  logic [INST_W-1:0] fill_inst,
  input  logic              free_en,
  input  logic [PTR_W-1:0]  free_idx,
  input  logic [PTR_W-1:0]  rd_idx,
  output logic [PC_W-1:0]   rd_pc,
  output logic [INST_W-1:0] rd_inst,
  output logic              rd_filled
);

  logic [PC_W-1:0]   pc_mem   [QDEPTH];
  logic [INST_W-1:0] inst_mem [QDEPTH];
  logic [QDEPTH-1:0] filled;

  always_ff @(posedge clk) begin
    if (alloc_en) pc_mem[alloc_idx] <= alloc_pc;
    if (fill_en)  inst_mem[fill_idx] <= fill_inst;
  end

  // Allocate and fill never target the same slot: fill only lands on
  // allocated-but-unfilled entries, allocate only on free ones.
  always_ff @(posedge clk) begin
    if (rst || clear) begin
      filled <= '0;
    end else begin
      if (free_en)  filled[free_idx]  <= 1'b0;
      if (alloc_en) filled[alloc_idx] <= 1'b0;
      if (fill_en)  filled[fill_idx]  <= 1'b1;
    end
  end

  assign rd_pc     = pc_mem[rd_idx];
  assign rd_inst   = inst_mem[rd_idx];
  assign rd_filled = filled[rd_idx];

endmodule

// File: rtl/fetch_queue.sv
// Decoupled fetch stage: issues sequential PCs to imem, buffers in-order
// responses and presents them to decode; redirects flush and squash.
module fetch_queue
  import fetch_pkg::*;
#(
  parameter int              PC_W     = PC_W_DEF,
  parameter int              INST_W   = INST_W_DEF,
  parameter logic [PC_W-1:0] RESET_PC = PC_W'(RESET_PC_DEF),
  parameter int              PC_STEP  = PC_STEP_DEF,
  parameter int              QDEPTH   = QDEPTH_DEF,
  localparam int             PTR_W    = $clog2(QDEPTH),
  localparam int             CNT_W    = PTR_W + 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              redirect_en,
  input  logic [PC_W-1:0]   redirect_pc,
  output logic              imem_req_valid,
  input  logic              imem_req_ready,
  output logic [PC_W-1:0]   imem_req_addr,
  input  logic              imem_rsp_valid,
  input  logic [INST_W-1:0] imem_rsp_data,
  output logic              id_valid,
  input  logic              id_ready,
  output logic [INST_W-1:0] id_inst,
  output logic [PC_W-1:0]   id_pc,
  output logic [CNT_W-1:0]  q_count
);

  localparam logic [PC_W-1:0]  STEP       = PC_W'(PC_STEP);
  localparam logic [PC_W-1:0]  ALIGN_MASK = ~(PC_W'(PC_STEP - 1));
  localparam logic [CNT_W:0]   DEPTH      = (CNT_W + 1)'(QDEPTH);

  logic [PC_W-1:0]  pc;
  logic [PTR_W-1:0] head, tail, fill;
  logic [CNT_W-1:0] occ, pend, drop_cnt;
  logic [CNT_W:0]   busy;
  logic             issue, rsp_fill, rsp_drop, deq, head_filled;

  // Stale responses still in flight occupy issue credit just like live entries.
  assign busy           = {1'b0, occ} + {1'b0, drop_cnt};
  assign imem_req_valid = !rst && (busy < DEPTH);
  assign imem_req_addr  = pc;
  assign issue          = imem_req_valid && imem_req_ready;
  assign rsp_drop       = imem_rsp_valid && (drop_cnt != '0);
  assign rsp_fill       = imem_rsp_valid && (drop_cnt == '0);
  assign id_valid       = head_filled;
  assign deq            = id_valid && id_ready;
  assign q_count        = occ;

  fetch_qmem #(
    .PC_W   (PC_W),
    .INST_W (INST_W),
    .QDEPTH (QDEPTH)
  ) u_qmem (
    .clk       (clk),
    .rst       (rst),
    .clear     (redirect_en),
    .alloc_en  (issue && !redirect_en),
    .alloc_idx (tail),
    .alloc_pc  (pc),
    .fill_en   (rsp_fill && !redirect_en),
    .fill_idx  (fill),
    .fill_inst (imem_rsp_data),
    .free_en   (deq && !redirect_en),
    .free_idx  (head),
    .rd_idx    (head),
    .rd_pc     (id_pc),
    .rd_inst   (id_inst),
    .rd_filled (head_filled)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      pc       <= RESET_PC;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      occ      <= '0;
      pend     <= '0;
      drop_cnt <= '0;
    end else if (redirect_en) begin
      // Every request still outstanding after this edge becomes stale:
      // old stale ones, unfilled entries and this cycle's issue, minus
      // whichever one responds right now.
      pc       <= redirect_pc & ALIGN_MASK;
      head     <= '0;
      tail     <= '0;
      fill     <= '0;
      occ      <= '0;
      pend     <= '0;
      drop_cnt <= drop_cnt + pend + CNT_W'(issue) - CNT_W'(imem_rsp_valid);
    end else begin
      if (issue) begin
        tail <= tail + PTR_W'(1);
        pc   <= pc + STEP;
      end
      if (rsp_fill) fill <= fill + PTR_W'(1);
      if (deq)      head <= head + PTR_W'(1);
      occ      <= occ + CNT_W'(issue) - CNT_W'(deq);
      pend     <= pend + CNT_W'(issue) - CNT_W'(rsp_fill);
      drop_cnt <= drop_cnt - CNT_W'(rsp_drop);
    end
  end

endmodule

// File: tb/tb_fetch_queue.sv
// Bench for fetch_queue: behavioural in-order memory plus a scoreboard of
// expected {pc, inst} pairs, with scenario tasks run in sequence.
module tb_fetch_queue;

  logic        clk = 1'b0;
  logic        rst;
  logic        redirect_en;
  logic [31:0] redirect_pc;
  logic        imem_req_valid;
  logic        imem_req_ready = 1'b0;
  logic [31:0] imem_req_addr;
  logic        imem_rsp_valid = 1'b0;
  logic [31:0] imem_rsp_data  = 32'h0;
  logic        id_valid;
  logic        id_ready;
  logic [31:0] id_inst;
  logic [31:0] id_pc;
  logic [2:0]  q_count;

  fetch_queue #(
    .PC_W     (32),
    .INST_W   (32),
    .RESET_PC (32'h0),
    .PC_STEP  (4),
    .QDEPTH   (4)
  ) dut (
    .clk            (clk),
    .rst            (rst),
    .redirect_en    (redirect_en),
    .redirect_pc    (redirect_pc),
    .imem_req_valid (imem_req_valid),
    .imem_req_ready (imem_req_ready),
    .imem_req_addr  (imem_req_addr),
    .imem_rsp_valid (imem_rsp_valid),
    .imem_rsp_data  (imem_rsp_data),
    .id_valid       (id_valid),
    .id_ready       (id_ready),
    .id_inst        (id_inst),
    .id_pc          (id_pc),
    .q_count        (q_count)
  );

  always #5 clk = ~clk;

  typedef struct { logic [31:0] addr; int due; } mreq_t;
  typedef struct { logic [31:0] pc; logic [31:0] inst; } exp_t;

  mreq_t       mq[$];
  exp_t        sb[$];
  exp_t        e_mon;
  int          tests = 0;
  int          fails = 0;
  int          cyc = 0;
  int          req_fires = 0;
  int          id_fires = 0;
  logic [31:0] exp_pc = 32'h0;
  bit          mem_rand = 1'b0;
  logic        mem_ready_cfg = 1'b1;
  int          lat_min = 1;
  int          lat_max = 1;

  function automatic logic [31:0] mem_word(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'h1357_9BDF;
  endfunction

  // Memory model and scoreboard; inputs settle at negedge+1, sampling at +2.
  always begin
    @(negedge clk);
    #1;
    cyc++;
    imem_req_ready = mem_rand ? ($urandom_range(0, 3) != 0) : mem_ready_cfg;
    if (!rst && mq.size() > 0 && mq[0].due <= cyc) begin
      imem_rsp_valid = 1'b1;
      imem_rsp_data  = mem_word(mq[0].addr);
    end else begin
      imem_rsp_valid = 1'b0;
      imem_rsp_data  = $urandom;
    end
    #1;
    if (rst) begin
      mq.delete();
      sb.delete();
      exp_pc = 32'h0;
    end else begin
      if (imem_rsp_valid) void'(mq.pop_front());
      if (imem_req_valid && imem_req_ready) begin
        req_fires++;
        tests++;
        if (imem_req_addr !== exp_pc) begin
          fails++;
          $display("FAIL req_addr: got %08h expected %08h (cycle %0d)", imem_req_addr, exp_pc, cyc);
        end
        mq.push_back('{addr: imem_req_addr, due: cyc + int'($urandom_range(lat_min, lat_max))});
        if (!redirect_en) sb.push_back('{pc: imem_req_addr, inst: mem_word(imem_req_addr)});
        exp_pc = exp_pc + 32'd4;
      end
      if (redirect_en) begin
        sb.delete();
        exp_pc = redirect_pc & 32'hFFFF_FFFC;
      end else if (id_valid && id_ready) begin
        id_fires++;
        tests++;
        if (sb.size() == 0) begin
          fails++;
          $display("FAIL id_unexpected: got pc %08h inst %08h, expected no instruction", id_pc, id_inst);
        end else begin
          e_mon = sb.pop_front();
          if (id_pc !== e_mon.pc || id_inst !== e_mon.inst) begin
            fails++;
            $display("FAIL id_data: got pc %08h inst %08h expected pc %08h inst %08h",
                     id_pc, id_inst, e_mon.pc, e_mon.inst);
          end
        end
      end
    end
  end

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    redirect_en = 1'b0;
    id_ready = 1'b0;
    repeat (2) @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    mem_rand = 1'b0;
    mem_ready_cfg = 1'b1;
    lat_min = 1;
    lat_max = 1;
    @(negedge clk);
    #3;
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rst_req_valid: got %b expected 0", imem_req_valid); end
    tests++;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL rst_id_valid: got %b expected 0", id_valid); end
    tests++;
    if (q_count !== 3'd0) begin fails++; $display("FAIL rst_q_count: got %0d expected 0", q_count); end
    @(negedge clk);
    rst = 1'b0;
    #3;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      fails++;
      $display("FAIL rst_first_req: got valid %b addr %08h expected valid 1 addr 00000000", imem_req_valid, imem_req_addr);
    end
  endtask

  task automatic test_stream();
    int base_id, base_req;
    mem_rand = 1'b0;
    mem_ready_cfg = 1'b1;
    lat_min = 1;
    lat_max = 1;
    do_reset();
    id_ready = 1'b1;
    #3;
    tests++;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL stream_c0_id_valid: got %b expected 0", id_valid); end
    @(negedge clk);
    #3;
    tests++;
    if (id_valid !== 1'b0) begin fails++; $display("FAIL stream_c1_id_valid: got %b expected 0", id_valid); end
    @(negedge clk);
    #3;
    tests++;
    if (id_valid !== 1'b1 || id_pc !== 32'h0) begin
      fails++;
      $display("FAIL stream_first_id: got valid %b pc %08h expected valid 1 pc 00000000", id_valid, id_pc);
    end
    base_id = id_fires;
    base_req = req_fires;
    repeat (20) @(negedge clk);
    #3;
    tests++;
    if (id_fires - base_id !== 20) begin fails++; $display("FAIL stream_id_rate: got %0d expected 20", id_fires - base_id); end
    tests++;
    if (req_fires - base_req !== 20) begin fails++; $display("FAIL stream_req_rate: got %0d expected 20", req_fires - base_req); end
  endtask

  task automatic test_full();
    int base_req;
    mem_rand = 1'b0;
    mem_ready_cfg = 1'b1;
    lat_min = 1;
    lat_max = 1;
    do_reset();
    base_req = req_fires;
    repeat (10) @(negedge clk);
    #3;
    tests++;
    if (req_fires - base_req !== 4) begin fails++; $display("FAIL full_req_count: got %0d expected 4", req_fires - base_req); end
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL full_req_valid: got %b expected 0", imem_req_valid); end
    tests++;
    if (q_count !== 3'd4) begin fails++; $display("FAIL full_q_count: got %0d expected 4", q_count); end
    @(negedge clk);
    id_ready = 1'b1;
    @(negedge clk);
    id_ready = 1'b0;
    repeat (4) @(negedge clk);
    #3;
    tests++;
    if (req_fires - base_req !== 5) begin fails++; $display("FAIL full_reopen_count: got %0d expected 5", req_fires - base_req); end
    tests++;
    if (q_count !== 3'd4 || imem_req_valid !== 1'b0) begin
      fails++;
      $display("FAIL full_refull: got q_count %0d valid %b expected 4 and 0", q_count, imem_req_valid);
    end
  endtask

  task automatic test_varlat();
    int base_id;
    mem_rand = 1'b1;
    lat_min = 1;
    lat_max = 5;
    do_reset();
    base_id = id_fires;
    repeat (300) begin
      id_ready = ($urandom_range(0, 3) != 0);
      @(negedge clk);
    end
    #3;
    tests++;
    if (id_fires - base_id < 40) begin fails++; $display("FAIL varlat_progress: got %0d expected at least 40", id_fires - base_id); end
  endtask

  task automatic wait_id(input string name, input logic [31:0] pc_exp);
    int n = 0;
    while (id_valid !== 1'b1 && n < 40) begin
      @(negedge clk);
      #3;
      n++;
    end
    tests++;
    if (id_valid !== 1'b1 || id_pc !== pc_exp || id_inst !== mem_word(pc_exp)) begin
      fails++;
      $display("FAIL %s: got valid %b pc %08h inst %08h expected valid 1 pc %08h inst %08h",
               name, id_valid, id_pc, id_inst, pc_exp, mem_word(pc_exp));
    end
  endtask

  task automatic test_redirect();
    mem_rand = 1'b0;
    mem_ready_cfg = 1'b1;
    lat_min = 4;
    lat_max = 4;
    do_reset();
    repeat (3) @(negedge clk);
    mem_ready_cfg = 1'b0;
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0103;
    #3;
    tests++;
    if (q_count !== 3'd3) begin fails++; $display("FAIL redir_inflight: got %0d expected 3", q_count); end
    @(negedge clk);
    redirect_en = 1'b0;
    mem_ready_cfg = 1'b1;
    id_ready = 1'b1;
    #3;
    tests++;
    if (imem_req_valid !== 1'b1 || imem_req_addr !== 32'h100) begin
      fails++;
      $display("FAIL redir_next_addr: got valid %b addr %08h expected valid 1 addr 00000100", imem_req_valid, imem_req_addr);
    end
    tests++;
    if (q_count !== 3'd0) begin fails++; $display("FAIL redir_flush: got %0d expected 0", q_count); end
    wait_id("redir_first_id", 32'h100);
  endtask

  task automatic test_collide();
    mem_rand = 1'b0;
    mem_ready_cfg = 1'b1;
    lat_min = 2;
    lat_max = 2;
    do_reset();
    id_ready = 1'b1;
    repeat (2) @(negedge clk);
    redirect_en = 1'b1;
    redirect_pc = 32'h0000_0300;
    #3;
    tests++;
    if (imem_req_valid !== 1'b1) begin fails++; $display("FAIL collide_issue: got %b expected 1", imem_req_valid); end
    @(negedge clk);
    redirect_en = 1'b0;
    #3;
    tests++;
    if (imem_req_addr !== 32'h300 || id_valid !== 1'b0 || q_count !== 3'd0) begin
      fails++;
      $display("FAIL collide_after: got addr %08h id_valid %b q_count %0d expected 00000300 0 0",
               imem_req_addr, id_valid, q_count);
    end
    wait_id("collide_first_id", 32'h300);
    repeat (10) @(negedge clk);
  endtask

  task automatic test_rst_mid();
    mem_rand = 1'b1;
    lat_min = 1;
    lat_max = 3;
    do_reset();
    repeat (25) begin
      id_ready = ($urandom_range(0, 1) != 0);
      @(negedge clk);
    end
    rst = 1'b1;
    id_ready = 1'b1;
    #3;
    tests++;
    if (imem_req_valid !== 1'b0) begin fails++; $display("FAIL rstmid_req_valid: got %b expected 0", imem_req_valid); end
    @(negedge clk);
    rst = 1'b0;
    #3;
    tests++;
    if (id_valid !== 1'b0 || q_count !== 3'd0 || imem_req_valid !== 1'b1 || imem_req_addr !== 32'h0) begin
      fails++;
      $display("FAIL rstmid_state: got id_valid %b q_count %0d req_valid %b addr %08h expected 0 0 1 00000000",
               id_valid, q_count, imem_req_valid, imem_req_addr);
    end
    repeat (40) @(negedge clk);
  endtask

  initial begin
    rst = 1'b1;
    redirect_en = 1'b0;
    redirect_pc = 32'h0;
    id_ready = 1'b0;
    test_reset();
    test_stream();
    test_full();
    test_varlat();
    test_redirect();
    test_collide();
    test_rst_mid();
    @(negedge clk);
    #3;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL timeout: simulation did not reach the summary within the time limit");
    $fatal(1, "timeout");
  end

endmodule
